// File: rtl/dm_lsu.sv
// rtl/dm_lsu.sv - load/store unit between the MEM stage and a word-wide data memory
// Sub-word stores merge by read-modify-write; loads are lane-extracted and extended.
module dm_lsu #(
    parameter int DM_AW       = 7,
    parameter bit CHECK_RANGE = 1'b1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [1:0]       req_size,
    input  logic             req_unsigned,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_rdata,
    output logic             rsp_err,
    output logic             dm_wr,
    output logic [DM_AW-1:0] dm_addr,
    output logic [31:0]      dm_din,
    input  logic [31:0]      dm_dout,
    output logic [1:0]       dm_memop
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RD, S_WR, S_RESP} state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_we;
    logic [1:0]       r_size;
    logic             r_uns;
    logic [DM_AW+1:0] r_addr;
    logic [31:0]      r_wdata;
    logic [31:0]      r_merge;
    logic [31:0]      r_rdata;
    logic             r_err;

    logic             w_hs;
    logic             w_misal;
    logic             w_range;
    logic             w_bad;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [31:0]      w_load;
    logic [31:0]      w_merge;

    assign w_hs = req_valid && (r_state == S_IDLE);

    always_comb begin
        w_misal = 1'b0;
        case (req_size)
            2'b00:   w_misal = 1'b0;
            2'b01:   w_misal = req_addr[0];
            2'b10:   w_misal = |req_addr[1:0];
            default: w_misal = 1'b1;
        endcase
        w_range = CHECK_RANGE && (|req_addr[31:DM_AW+2]);
        w_bad   = w_misal || w_range;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_hs) w_next = w_bad ? S_RESP : (req_we ? S_RD : S_LOAD);
            S_LOAD: w_next = S_RESP;
            S_RD:   w_next = S_WR;
            S_WR:   w_next = S_RESP;
            S_RESP: if (rsp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (r_state == S_IDLE);
        rsp_valid = (r_state == S_RESP);
        dm_wr     = (r_state == S_WR);
        dm_addr   = (r_state == S_IDLE) ? req_addr[DM_AW+1:2] : r_addr[DM_AW+1:2];
    end

    assign dm_din    = r_merge;
    assign dm_memop  = 2'b00;
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

    // Lane extraction and extension for loads.
    always_comb begin
        w_byte = dm_dout[{r_addr[1:0], 3'b000} +: 8];
        w_half = dm_dout[{r_addr[1], 4'b0000} +: 16];
        case (r_size)
            2'b00:   w_load = {{24{~r_uns & w_byte[7]}}, w_byte};
            2'b01:   w_load = {{16{~r_uns & w_half[15]}}, w_half};
            default: w_load = dm_dout;
        endcase
    end

    always_comb begin
        w_merge = dm_dout;
        case (r_size)
            2'b00:   w_merge[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
            2'b01:   w_merge[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
            default: w_merge = r_wdata;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_we    <= 1'b0;
            r_size  <= 2'b00;
            r_uns   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_merge <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_hs) begin
                r_we    <= req_we;
                r_size  <= req_size;
                r_uns   <= req_unsigned;
                r_addr  <= req_addr[DM_AW+1:0];
                r_wdata <= req_wdata;
                r_rdata <= '0;
                r_err   <= w_bad;
            end
            if (r_state == S_LOAD) r_rdata <= w_load;
            if (r_state == S_RD && r_we) r_merge <= w_merge;
        end
    end

endmodule
